radix4_divider: RTL

- Unsigned 32/32 iterative divider that sits directly downstream of the integer mul/div unit; that unit feeds it magnitudes and applies sign correction to its outputs.
- Radix-4 restoring algorithm: retires 2 quotient bits per cycle and produces the quotient and remainder together.
- Uses a single-cycle start pulse and a single-cycle done pulse. Results stay stable until the next start.

---
 rtl/radix4_div_pkg.sv | 23 ++
 rtl/radix4_div_step.sv | 45 ++++
 rtl/radix4_divider.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/radix4_div_pkg.sv
// Shared definitions for the radix-4 divider slice: FSM state encoding, the
// default operand width and the helper used to size the iteration counter.
package radix4_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int XLEN_DEFAULT = 32;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << width) < value) width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/radix4_div_step.sv
// One radix-4 restoring step, purely combinational.
// Ports:
//   r_i      partial remainder (always < d)
//   bits_i   next two dividend bits, MSB first
//   d_i      divisor
//   d2_i     2*divisor, XLEN+2 bits
//   d3_i     3*divisor, XLEN+2 bits
//   k_o      quotient digit 0..3, largest k with k*d <= {r, bits}
//   r_next_o new partial remainder {r, bits} - k*d
module radix4_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] r_i,
  input  logic [1:0]      bits_i,
  input  logic [XLEN-1:0] d_i,
  input  logic [XLEN+1:0] d2_i,
  input  logic [XLEN+1:0] d3_i,
  output logic [1:0]      k_o,
  output logic [XLEN-1:0] r_next_o
);

  logic [XLEN+1:0] r4;
  logic [XLEN-1:0] sub;

  assign r4 = {r_i, bits_i};

  // The difference is always < d, so subtracting only the low XLEN bits
  // (modulo 2^XLEN) gives the exact remainder.
  always_comb begin
    k_o = 2'd0;
    sub = '0;
    if (r4 >= d3_i) begin
      k_o = 2'd3;
      sub = d3_i[XLEN-1:0];
    end else if (r4 >= d2_i) begin
      k_o = 2'd2;
      sub = d2_i[XLEN-1:0];
    end else if (r4 >= {2'b00, d_i}) begin
      k_o = 2'd1;
      sub = d_i;
    end
    r_next_o = r4[XLEN-1:0] - sub;
  end

endmodule

// File: rtl/radix4_divider.sv
// Unsigned XLEN/XLEN iterative radix-4 restoring divider, 2 quotient bits
// per cycle. Start is input_valid && ready; output_valid pulses for one cycle
// and quotient/remainder hold until the next operation completes.
// Optional macro RADIX4_DIV_EARLY_EXIT_EN: skips leading zero digit pairs of
// the dividend and finishes zero-dividend / zero-divisor cases immediately.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   dividend, divisor     operands, sampled on the accept edge
//   input_valid, ready    start handshake
//   quotient, remainder   results
//   output_valid          one-cycle completion pulse
//
// state | meaning
// IDLE  | ready, waiting for input_valid
// RUN   | one radix-4 digit per cycle, counter counts down to 0
// DONE  | output_valid high, results just loaded
module radix4_divider
  import radix4_div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            input_valid,
  output logic            ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            output_valid
);

  localparam int CW = clog2(XLEN / 2);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] r_q;
  // Dividend bits leave at the top while quotient digits enter at the bottom.
  logic [XLEN-1:0] dq_q;
  logic [XLEN-1:0] d_q;
  logic [XLEN+1:0] d3_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;

  logic [XLEN+1:0] d2;
  logic [1:0]      k;
  logic [XLEN-1:0] r_next;

  assign d2 = {1'b0, d_q, 1'b0};

  radix4_div_step #(.XLEN(XLEN)) u_step (
    .r_i      (r_q),
    .bits_i   (dq_q[XLEN-1:XLEN-2]),
    .d_i      (d_q),
    .d2_i     (d2),
    .d3_i     (d3_q),
    .k_o      (k),
    .r_next_o (r_next)
  );

`ifdef RADIX4_DIV_EARLY_EXIT_EN
  function automatic logic [CW:0] lz_pairs(input logic [XLEN-1:0] v);
    logic [CW:0] n;
    logic        hit;
    n   = '0;
    hit = 1'b0;
    for (int i = XLEN / 2 - 1; i >= 0; i--) begin
      if (!hit && v[2*i +: 2] == 2'b00) n = n + 1'b1;
      else hit = 1'b1;
    end
    return n;
  endfunction

  logic [CW:0] p;
  logic        zero_op;
  assign p       = lz_pairs(dividend);
  assign zero_op = (dividend == '0) || (divisor == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (input_valid) begin
          state_d = RUN;
`ifdef RADIX4_DIV_EARLY_EXIT_EN
          if (zero_op) state_d = DONE;
`endif
        end
      end
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      r_q    <= '0;
      dq_q   <= '0;
      d_q    <= '0;
      d3_q   <= '0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (input_valid) begin
            d_q  <= divisor;
            d3_q <= {2'b00, divisor} + {1'b0, divisor, 1'b0};
            r_q  <= '0;
`ifdef RADIX4_DIV_EARLY_EXIT_EN
            dq_q  <= dividend << {p, 1'b0};
            cnt_q <= CW'(XLEN / 2 - 1) - p[CW-1:0];
            if (zero_op) begin
              quot_q <= (divisor == '0) ? '1 : '0;
              rem_q  <= dividend;
            end
`else
            dq_q  <= dividend;
            cnt_q <= CW'(XLEN / 2 - 1);
`endif
          end
        end
        RUN: begin
          r_q   <= r_next;
          dq_q  <= {dq_q[XLEN-3:0], k};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            quot_q <= {dq_q[XLEN-3:0], k};
            rem_q  <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready        = (state_q == IDLE);
  assign output_valid = (state_q == DONE);
  assign quotient     = quot_q;
  assign remainder    = rem_q;

endmodule
